// File: rtl/tetris_input_timer.sv
// ---------------------------------------------------------------------------
// tetris_input_timer
//   Front end of the game core. Conditions the four raw push-buttons into
//   single-cycle move/rotate strobes and generates the score-dependent
//   gravity strobe.
//
//   Optional feature macro: TETRIS_AUTOREPEAT_EN
//     defined   : held left/right/down keys auto-repeat (rotate never repeats)
//     undefined : exactly one strobe per accepted press, no repeat hardware
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   key_n[3:0] in   raw buttons, active-low, asynchronous
//                   [3]=left [2]=right [1]=down [0]=rot
//   score[7:0] in   current score from the core
//   game_over  in   core game-over flag
//   k_left     out  one-cycle move-left strobe
//   k_right    out  one-cycle move-right strobe
//   k_down     out  one-cycle soft-drop strobe
//   k_rot      out  one-cycle rotate strobe
//   drop_tick  out  one-cycle gravity strobe
//
// Handshake: none. Every output is a registered single-cycle pulse with no
// back-pressure; the consumer must act on it in the cycle it is high.
// ---------------------------------------------------------------------------
module tetris_input_timer #(
    parameter int DEB_CYC   = 500_000,
    parameter int REP_DLY   = 15_000_000,
    parameter int REP_PER   = 5_000_000,
    parameter int DROP_BASE = 50_000_000,
    parameter int DROP_STEP = 2_500_000,
    parameter int DROP_MIN  = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_n,
    input  logic [7:0] score,
    input  logic       game_over,
    output logic       k_left,
    output logic       k_right,
    output logic       k_down,
    output logic       k_rot,
    output logic       drop_tick
);

    localparam int DW = $clog2(DEB_CYC) + 1;

    // -----------------------------------------------------------------------
    // Synchroniser, active-high level register and per-key debounce
    // -----------------------------------------------------------------------
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic [3:0]    lvl;       // synced level, active-high
    logic [3:0]    acc;       // accepted (debounced) level
    logic [3:0]    acc_d;     // accepted level one cycle ago, for edge detect
    logic [DW-1:0] deb_cnt [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 4'hF;
            sync2 <= 4'hF;
            lvl   <= 4'h0;
            acc   <= 4'h0;
            acc_d <= 4'h0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= key_n;
            sync2 <= sync1;
            lvl   <= ~sync2;
            acc_d <= acc;
            for (int i = 0; i < 4; i++) begin
                // The counter measures an unbroken run of cycles where the
                // synced level disagrees with the accepted one.
                if (lvl[i] == acc[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DW'(DEB_CYC - 1)) begin
                    acc[i]     <= lvl[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic [3:0] press;
    assign press = acc & ~acc_d;

    // -----------------------------------------------------------------------
    // Auto-repeat for left/right/down. Index j covers key j+1.
    // -----------------------------------------------------------------------
    logic [2:0] rep_fire;

`ifdef TETRIS_AUTOREPEAT_EN
    localparam int REP_MAX = (REP_DLY > REP_PER) ? REP_DLY : REP_PER;
    localparam int RW      = $clog2(REP_MAX) + 1;

    logic [2:0]    rep_act;    // repeat timer armed for this key
    logic [2:0]    rep_first;  // waiting for the first (longer) interval
    logic [RW-1:0] rep_cnt [3];

    always_comb begin
        rep_fire = 3'b000;
        for (int j = 0; j < 3; j++) begin
            rep_fire[j] = rep_act[j] & acc[j+1] &
                          (rep_cnt[j] == (rep_first[j] ? RW'(REP_DLY - 1)
                                                       : RW'(REP_PER - 1)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_act   <= 3'b000;
            rep_first <= 3'b000;
            for (int j = 0; j < 3; j++) begin
                rep_cnt[j] <= '0;
            end
        end else begin
            for (int j = 0; j < 3; j++) begin
                if (game_over || !acc[j+1]) begin
                    // Release or game over cancels the repeat at once.
                    rep_act[j]   <= 1'b0;
                    rep_first[j] <= 1'b0;
                    rep_cnt[j]   <= '0;
                end else if (press[j+1]) begin
                    rep_act[j]   <= 1'b1;
                    rep_first[j] <= 1'b1;
                    rep_cnt[j]   <= '0;
                end else if (rep_act[j]) begin
                    if (rep_fire[j]) begin
                        rep_first[j] <= 1'b0;
                        rep_cnt[j]   <= '0;
                    end else begin
                        rep_cnt[j] <= rep_cnt[j] + 1'b1;
                    end
                end
            end
        end
    end
`else
    assign rep_fire = 3'b000;
`endif

    // -----------------------------------------------------------------------
    // Strobe selection: left+right together cancel each other, game over
    // silences everything. strobe_nx is the value the output flops take.
    // -----------------------------------------------------------------------
    logic [3:0] strobe_nx;

    always_comb begin
        strobe_nx = {press[3:1] | rep_fire, press[0]};
        if (acc[3] && acc[2]) begin
            strobe_nx[3:2] = 2'b00;
        end
        if (game_over) begin
            strobe_nx = 4'b0000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_left  <= 1'b0;
            k_right <= 1'b0;
            k_down  <= 1'b0;
            k_rot   <= 1'b0;
        end else begin
            k_left  <= strobe_nx[3];
            k_right <= strobe_nx[2];
            k_down  <= strobe_nx[1];
            k_rot   <= strobe_nx[0];
        end
    end

    // -----------------------------------------------------------------------
    // Gravity
    // -----------------------------------------------------------------------
    logic [31:0] prod;
    logic [31:0] p_calc;
    logic [31:0] p_reg;
    logic [31:0] p_eff;
    logic [31:0] drop_cnt;
    logic        first;    // first cycle after reset release
    logic        wrap;

    always_comb begin
        prod = 32'(score) * 32'(DROP_STEP);
        if (prod >= 32'(DROP_BASE)) begin
            p_calc = 32'(DROP_MIN);
        end else if ((32'(DROP_BASE) - prod) < 32'(DROP_MIN)) begin
            p_calc = 32'(DROP_MIN);
        end else begin
            p_calc = 32'(DROP_BASE) - prod;
        end
    end

    // In the very first cycle the period register has not been loaded yet,
    // so the freshly computed period stands in for it.
    assign p_eff = first ? p_calc : p_reg;
    assign wrap  = (drop_cnt == (p_eff - 32'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt  <= '0;
            p_reg     <= 32'(DROP_BASE);
            first     <= 1'b1;
            drop_tick <= 1'b0;
        end else begin
            first <= 1'b0;
            if (first) begin
                p_reg <= p_calc;
            end
            // A soft-drop restarts the gravity period and beats a
            // coincident wrap, so gravity never doubles a soft-drop.
            if (game_over || strobe_nx[1]) begin
                drop_cnt  <= '0;
                drop_tick <= 1'b0;
            end else if (wrap) begin
                drop_cnt  <= '0;
                drop_tick <= 1'b1;
                p_reg     <= p_calc;
            end else begin
                drop_cnt  <= drop_cnt + 32'd1;
                drop_tick <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tetris_input_timer.sv
// ---------------------------------------------------------------------------
// tb_tetris_input_timer
//   Self-checking bench for tetris_input_timer with small timing parameters.
//   Each scenario fills per-edge stimulus tables, replays them from a fresh
//   reset, records the outputs 1 time unit after each rising edge and checks
//   them against a reference model derived from the behavioural rules
//   (acceptance after DEB_CYC disagreeing samples, strobe schedule, gravity
//   period arithmetic). Edge 1 is the first rising edge after reset release.
//   Output vector bit order: {k_left, k_right, k_down, k_rot, drop_tick}.
// ---------------------------------------------------------------------------
module tb_tetris_input_timer;

    localparam int DEB_CYC   = 4;
    localparam int REP_DLY   = 20;
    localparam int REP_PER   = 5;
    localparam int DROP_BASE = 100;
    localparam int DROP_STEP = 10;
    localparam int DROP_MIN  = 30;
    localparam int MAXN      = 700;

    logic       clk;
    logic       rst_n;
    logic [3:0] key_n;
    logic [7:0] score;
    logic       game_over;
    logic       k_left;
    logic       k_right;
    logic       k_down;
    logic       k_rot;
    logic       drop_tick;

    int total = 0;
    int bad   = 0;

    logic [3:0] kn  [1:MAXN];
    logic [7:0] sc  [1:MAXN];
    logic       go  [1:MAXN];
    logic [4:0] obs [1:MAXN];
    logic [3:0] acc_h [0:MAXN];
    logic [4:0] exp_q [$];

    tetris_input_timer #(
        .DEB_CYC  (DEB_CYC),
        .REP_DLY  (REP_DLY),
        .REP_PER  (REP_PER),
        .DROP_BASE(DROP_BASE),
        .DROP_STEP(DROP_STEP),
        .DROP_MIN (DROP_MIN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_n    (key_n),
        .score    (score),
        .game_over(game_over),
        .k_left   (k_left),
        .k_right  (k_right),
        .k_down   (k_down),
        .k_rot    (k_rot),
        .drop_tick(drop_tick)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model helpers ----------------
    function automatic int calc_p(input logic [7:0] s);
        int prod;
        prod = int'(s) * DROP_STEP;
        if (prod >= DROP_BASE) return DROP_MIN;
        if (DROP_BASE - prod < DROP_MIN) return DROP_MIN;
        return DROP_BASE - prod;
    endfunction

    // Fills exp_q with the expected output vector for edges 1..n.
    task automatic build_expected(input int n);
        logic [3:0] a, nw, prev, prev2, prs, s;
        logic       lv, diff, tick;
        int         nf [4];
        int         p, start;
        exp_q.delete();
        acc_h[0] = 4'h0;
        // A key level is accepted once the last DEB_CYC samples, taken 3
        // edges earlier (2 sync stages + level stage), all disagree with it.
        for (int t = 1; t <= n; t++) begin
            a  = acc_h[t-1];
            nw = a;
            for (int k = 0; k < 4; k++) begin
                diff = 1'b1;
                for (int j = t - 2 - DEB_CYC; j <= t - 3; j++) begin
                    lv = (j >= 1) ? ~kn[j][k] : 1'b0;
                    if (lv == a[k]) diff = 1'b0;
                end
                if (diff) nw[k] = ~a[k];
            end
            acc_h[t] = nw;
        end
        for (int k = 0; k < 4; k++) nf[k] = -1;
        p     = calc_p(sc[1]);
        start = 0;
        for (int t = 1; t <= n; t++) begin
            prev  = acc_h[t-1];
            prev2 = (t >= 2) ? acc_h[t-2] : 4'h0;
            prs   = prev & ~prev2;
            s     = 4'h0;
            for (int k = 0; k < 4; k++) begin
                logic fire;
                fire = 1'b0;
`ifdef TETRIS_AUTOREPEAT_EN
                if (k != 0) begin
                    if (go[t] || !prev[k]) nf[k] = -1;
                    else if (prs[k]) nf[k] = t + REP_DLY;
                    else if (nf[k] == t) begin
                        fire  = 1'b1;
                        nf[k] = t + REP_PER;
                    end
                end
`endif
                s[k] = !go[t] && (prs[k] || fire);
            end
            if (prev[3] && prev[2]) s[3:2] = 2'b00;
            tick = 1'b0;
            if (go[t] || s[1]) start = t;
            else if (t - start == p) begin
                tick  = 1'b1;
                start = t;
                p     = calc_p(sc[t]);
            end
            exp_q.push_back({s[3], s[2], s[1], s[0], tick});
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_stim(input int n);
        for (int t = 1; t <= n; t++) begin
            kn[t] = 4'hF;
            sc[t] = 8'd0;
            go[t] = 1'b0;
        end
    endtask

    task automatic set_key(input int k, input int t0, input int t1);
        for (int t = t0; t <= t1; t++) kn[t][k] = 1'b0;
    endtask

    // Resets the DUT, then replays edges 1..n and records the outputs.
    task automatic run_record(input int n);
        rst_n     = 1'b0;
        key_n     = 4'hF;
        score     = sc[1];
        game_over = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        key_n     = kn[1];
        score     = sc[1];
        game_over = go[1];
        for (int t = 1; t <= n; t++) begin
            @(posedge clk);
            #1;
            obs[t] = {k_left, k_right, k_down, k_rot, drop_tick};
            if (t < n) begin
                key_n     = kn[t+1];
                score     = sc[t+1];
                game_over = go[t+1];
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_n     = 1'b0;
        key_n     = 4'h0;
        score     = 8'd200;
        game_over = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        total++;
        if ({k_left, k_right, k_down, k_rot, drop_tick} !== 5'b0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=00000",
                     {k_left, k_right, k_down, k_rot, drop_tick});
        end
    endtask

    task automatic test_rot;
        int n, cnt;
        logic [4:0] e;
        n = 90;
        clear_stim(n);
        set_key(0, 1, 50);
        run_record(n);
        build_expected(n);
        cnt = 0;
        for (int t = 1; t <= n; t++) begin
            e = exp_q.pop_front();
            if (obs[t][1]) cnt++;
            total++;
            if (obs[t] !== e) begin
                bad++;
                $display("FAIL rot_model t=%0d got=%b exp=%b", t, obs[t], e);
            end
        end
        total++;
        if (obs[8][1] !== 1'b1 || cnt != 1) begin
            bad++;
            $display("FAIL rot_edge got_at8=%b count=%0d exp=1,1", obs[8][1], cnt);
        end
    endtask

    task automatic test_glitch_left;
        int n, first_t;
        logic [4:0] e;
        n = 90;
        clear_stim(n);
        set_key(3, 5, 7);
        set_key(3, 20, 60);
        run_record(n);
        build_expected(n);
        first_t = 0;
        for (int t = 1; t <= n; t++) begin
            e = exp_q.pop_front();
            if (obs[t][4] && first_t == 0) first_t = t;
            total++;
            if (obs[t] !== e) begin
                bad++;
                $display("FAIL glitch_model t=%0d got=%b exp=%b", t, obs[t], e);
            end
        end
        total++;
        if (first_t != 27) begin
            bad++;
            $display("FAIL glitch_first_left got=%0d exp=27", first_t);
        end
    endtask

    task automatic test_repeat_right;
        int n, cnt;
        logic [4:0] e;
        n = 100;
        clear_stim(n);
        set_key(2, 1, 60);
        run_record(n);
        build_expected(n);
        cnt = 0;
        for (int t = 1; t <= n; t++) begin
            e = exp_q.pop_front();
            if (obs[t][3]) cnt++;
            total++;
            if (obs[t] !== e) begin
                bad++;
                $display("FAIL repeat_model t=%0d got=%b exp=%b", t, obs[t], e);
            end
        end
        total++;
`ifdef TETRIS_AUTOREPEAT_EN
        // 8, 28, 33, ... 63; release accepted at edge 67
        if (cnt != 9 || obs[8][3] !== 1'b1 || obs[28][3] !== 1'b1 || obs[33][3] !== 1'b1) begin
            bad++;
            $display("FAIL repeat_count got=%0d exp=9", cnt);
        end
`else
        if (cnt != 1 || obs[8][3] !== 1'b1) begin
            bad++;
            $display("FAIL repeat_count got=%0d exp=1", cnt);
        end
`endif
    endtask

    task automatic test_drop;
        int n, cnt;
        logic [4:0] e;
        logic exp_tick;
        n = 370;
        clear_stim(n);
        for (int t = 150; t <= n; t++) sc[t] = 8'd5;
        for (int t = 260; t <= n; t++) sc[t] = 8'd9;
        run_record(n);
        build_expected(n);
        cnt = 0;
        for (int t = 1; t <= n; t++) begin
            e = exp_q.pop_front();
            total++;
            if (obs[t] !== e) begin
                bad++;
                $display("FAIL drop_model t=%0d got=%b exp=%b", t, obs[t], e);
            end
            exp_tick = (t == 100 || t == 200 || t == 250 || t == 300 || t == 330 || t == 360);
            if (obs[t][0] !== exp_tick) cnt++;
        end
        total++;
        if (cnt != 0) begin
            bad++;
            $display("FAIL drop_schedule wrong_edges=%0d exp=0", cnt);
        end
    endtask

    task automatic test_down_restart;
        int n;
        logic [4:0] e;
        n = 230;
        clear_stim(n);
        set_key(1, 93, 97);
        run_record(n);
        build_expected(n);
        for (int t = 1; t <= n; t++) begin
            e = exp_q.pop_front();
            total++;
            if (obs[t] !== e) begin
                bad++;
                $display("FAIL down_model t=%0d got=%b exp=%b", t, obs[t], e);
            end
        end
        total++;
        if (obs[100][2] !== 1'b1 || obs[100][0] !== 1'b0 || obs[200][0] !== 1'b1) begin
            bad++;
            $display("FAIL down_restart got_down=%b tick100=%b tick200=%b exp=1,0,1",
                     obs[100][2], obs[100][0], obs[200][0]);
        end
    endtask

    task automatic test_game_over;
        int n, nz;
        logic [4:0] e;
        n = 260;
        clear_stim(n);
        for (int t = 40; t <= 130; t++) go[t] = 1'b1;
        set_key(1, 45, 55);
        set_key(3, 60, 70);
        set_key(0, 100, 180);
        run_record(n);
        build_expected(n);
        nz = 0;
        for (int t = 1; t <= n; t++) begin
            e = exp_q.pop_front();
            if (go[t] && obs[t] !== 5'b0) nz++;
            total++;
            if (obs[t] !== e) begin
                bad++;
                $display("FAIL gameover_model t=%0d got=%b exp=%b", t, obs[t], e);
            end
        end
        total++;
        if (nz != 0 || obs[230][0] !== 1'b1) begin
            bad++;
            $display("FAIL gameover_quiet nonzero=%0d tick230=%b exp=0,1", nz, obs[230][0]);
        end
    endtask

    task automatic test_left_right;
        int n, cnt;
        logic [4:0] e;
        n = 90;
        clear_stim(n);
        set_key(3, 1, 50);
        set_key(2, 1, 50);
        run_record(n);
        build_expected(n);
        cnt = 0;
        for (int t = 1; t <= n; t++) begin
            e = exp_q.pop_front();
            if (obs[t][4] || obs[t][3]) cnt++;
            total++;
            if (obs[t] !== e) begin
                bad++;
                $display("FAIL lr_model t=%0d got=%b exp=%b", t, obs[t], e);
            end
        end
        total++;
        if (cnt != 0) begin
            bad++;
            $display("FAIL lr_suppress strobes=%0d exp=0", cnt);
        end
    endtask

    task automatic test_reset_mid;
        int n, cnt;
        n = 100;
        clear_stim(MAXN);
        run_record(n);
        total++;
        if (obs[100][0] !== 1'b1) begin
            bad++;
            $display("FAIL mid_pre_tick got=%b exp=1", obs[100][0]);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if ({k_left, k_right, k_down, k_rot, drop_tick} !== 5'b0) begin
            bad++;
            $display("FAIL mid_async_reset got=%b exp=00000",
                     {k_left, k_right, k_down, k_rot, drop_tick});
        end
        n = 120;
        run_record(n);
        cnt = 0;
        for (int t = 1; t <= n; t++) begin
            if (obs[t][0] !== (t == 100)) cnt++;
        end
        total++;
        if (cnt != 0) begin
            bad++;
            $display("FAIL mid_first_tick wrong_edges=%0d exp=0", cnt);
        end
    endtask

    task automatic test_random;
        int n, t, len, gs, ge;
        logic       lv;
        logic [7:0] s;
        logic [4:0] e;
        n = 600;
        for (int it = 0; it < 4; it++) begin
            clear_stim(n);
            for (int k = 0; k < 4; k++) begin
                t  = 1;
                lv = 1'b1;
                while (t <= n) begin
                    len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5)
                                                      : $urandom_range(5, 60);
                    for (int j = 0; j < len && t <= n; j++) begin
                        kn[t][k] = lv;
                        t++;
                    end
                    lv = ~lv;
                end
            end
            t = 1;
            while (t <= n) begin
                len = $urandom_range(20, 150);
                s   = 8'($urandom_range(0, 12));
                for (int j = 0; j < len && t <= n; j++) begin
                    sc[t] = s;
                    t++;
                end
            end
            if ($urandom_range(0, 1) == 1) begin
                gs = $urandom_range(100, 400);
                ge = gs + $urandom_range(5, 60);
                for (int j = gs; j <= ge; j++) go[j] = 1'b1;
            end
            run_record(n);
            build_expected(n);
            for (int q = 1; q <= n; q++) begin
                e = exp_q.pop_front();
                total++;
                if (obs[q] !== e) begin
                    bad++;
                    $display("FAIL random it=%0d t=%0d got=%b exp=%b", it, q, obs[q], e);
                end
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n     = 1'b0;
        key_n     = 4'hF;
        score     = 8'd0;
        game_over = 1'b0;
        test_reset();
        test_rot();
        test_glitch_left();
        test_repeat_right();
        test_drop();
        test_down_restart();
        test_game_over();
        test_left_right();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
